disparity_wta_scheduler: RTL

- Sequences the census-window similarity datapath through the disparity search range for one reference pixel at a time.
- Issues one candidate disparity per cycle to the datapath, collects the returned window costs in order, and performs winner-take-all (minimum-cost) selection.
- Sits between the census/line-buffer front end, which requests a search, and the disparity output stage.

---
 rtl/disparity_wta_scheduler_pkg.sv | 22 ++
 rtl/disparity_wta_scheduler_wta_min_tracker.sv | 49 ++++
 rtl/disparity_wta_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/disparity_wta_scheduler_pkg.sv
// Shared definitions for the disparity winner-take-all scheduler.
// The cost width is derived from the census window geometry so the
// similarity datapath and the scheduler always agree on it.
package disparity_wta_scheduler_pkg;

    // Census window geometry used by the similarity datapath
    localparam int WC = 7;
    localparam int WH = 13;

    // Worst-case summed Hamming cost over the window, rounded up to bits
    localparam int COST_W = $clog2((WC * WC / 2) * WH * WH);

    // Default disparity search range
    localparam int ND_DEFAULT = 64;

    // Scheduler FSM encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/disparity_wta_scheduler_wta_min_tracker.sv
// Running minimum over the returned window costs for one search.
// Strict less-than keeps the earliest (lowest) disparity on ties.
// The next-state values are exported so the caller can capture a result
// that already includes a return arriving in the same cycle.
module wta_min_tracker #(
    parameter int NCOST = 12,
    parameter int NDBIT = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             upd_i,
    input  logic [NCOST-1:0] cost_i,
    input  logic [NDBIT-1:0] disp_i,
    output logic [NCOST-1:0] best_cost_d_o,
    output logic [NDBIT-1:0] best_disp_d_o
);

    logic [NCOST-1:0] best_cost_q, best_cost_d;
    logic [NDBIT-1:0] best_disp_q, best_disp_d;

    // Clear on start, otherwise take a strictly smaller cost
    always_comb begin
        best_cost_d = best_cost_q;
        best_disp_d = best_disp_q;
        if (start_i) begin
            best_cost_d = '1;
            best_disp_d = '0;
        end else if (upd_i && (cost_i < best_cost_q)) begin
            best_cost_d = cost_i;
            best_disp_d = disp_i;
        end
    end

    // Best-so-far registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            best_cost_q <= '1;
            best_disp_q <= '0;
        end else begin
            best_cost_q <= best_cost_d;
            best_disp_q <= best_disp_d;
        end
    end

    assign best_cost_d_o = best_cost_d;
    assign best_disp_d_o = best_disp_d;

endmodule

// File: rtl/disparity_wta_scheduler.sv
// Disparity search scheduler: issues candidates 0..dmax to the census
// similarity datapath one per cycle, collects the in-order cost returns
// and reports the minimum-cost disparity with a one-cycle strobe.
// i_dmax carries one bit beyond the disparity index so an out-of-range
// request can be seen, flagged and clamped instead of silently wrapping.
module disparity_wta_scheduler
    import disparity_wta_scheduler_pkg::*;
#(
    parameter  int ND    = ND_DEFAULT,
    parameter  int NCOST = COST_W,
    localparam int NDBIT = $clog2(ND),
    localparam int DMW   = NDBIT + 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_req,
    output logic             o_ready,
    input  logic [DMW-1:0]   i_dmax,
    output logic             o_sim_dval,
    output logic [NDBIT-1:0] o_sim_disp,
    input  logic             i_cost_dval,
    input  logic [NCOST-1:0] i_cost,
    output logic             o_dval,
    output logic [NDBIT-1:0] o_disp,
    output logic [NCOST-1:0] o_cost,
    output logic             o_err
);

    // Return counter is one bit wider so dmax+1 == ND does not wrap
    localparam int             CW       = NDBIT + 1;
    localparam logic [DMW-1:0] DMAX_LIM = DMW'(ND - 1);

    logic [1:0]       state_q, state_d;
    logic [NDBIT-1:0] dmax_q, dmax_d;
    logic [CW-1:0]    ret_q, ret_d;
    logic [CW-1:0]    ret_tgt;
    logic             ready_q, ready_d;
    logic             sim_dval_q, sim_dval_d;
    logic [NDBIT-1:0] sim_disp_q, sim_disp_d;
    logic             dval_q, dval_d;
    logic [NDBIT-1:0] disp_q, disp_d;
    logic [NCOST-1:0] cost_q, cost_d;
    logic             err_q, err_d;

    logic             trk_start;
    logic             trk_upd;
    logic [NCOST-1:0] trk_cost_nxt;
    logic [NDBIT-1:0] trk_disp_nxt;

    assign ret_tgt = CW'(dmax_q) + CW'(1);

    wta_min_tracker #(
        .NCOST (NCOST),
        .NDBIT (NDBIT)
    ) u_trk (
        .clk_i         (i_clk),
        .rst_ni        (i_rstn),
        .start_i       (trk_start),
        .upd_i         (trk_upd),
        .cost_i        (i_cost),
        .disp_i        (ret_q[NDBIT-1:0]),
        .best_cost_d_o (trk_cost_nxt),
        .best_disp_d_o (trk_disp_nxt)
    );

    // FSM, issue/return counting and result capture
    always_comb begin
        state_d    = state_q;
        dmax_d     = dmax_q;
        ret_d      = ret_q;
        ready_d    = ready_q;
        sim_dval_d = sim_dval_q;
        sim_disp_d = sim_disp_q;
        dval_d     = 1'b0;
        disp_d     = disp_q;
        cost_d     = cost_q;
        err_d      = err_q;
        trk_start  = 1'b0;
        trk_upd    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A return with no search in flight is a protocol error
                if (i_cost_dval) err_d = 1'b1;
                if (i_req) begin
                    trk_start  = 1'b1;
                    if (i_dmax > DMAX_LIM) begin
                        dmax_d = NDBIT'(ND - 1);
                        err_d  = 1'b1;
                    end else begin
                        dmax_d = i_dmax[NDBIT-1:0];
                    end
                    ret_d      = '0;
                    sim_disp_d = '0;
                    sim_dval_d = 1'b1;
                    ready_d    = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE, S_DRAIN: begin
                if (i_cost_dval) begin
                    trk_upd = 1'b1;
                    ret_d   = ret_q + CW'(1);
                end
                if (state_q == S_ISSUE) begin
                    if (sim_disp_q == dmax_q) begin
                        sim_dval_d = 1'b0;
                        state_d    = S_DRAIN;
                    end else begin
                        sim_disp_d = sim_disp_q + NDBIT'(1);
                    end
                end
                // Final return seen: capture the winner including it
                if (ret_d == ret_tgt) begin
                    sim_dval_d = 1'b0;
                    dval_d     = 1'b1;
                    disp_d     = trk_disp_nxt;
                    cost_d     = trk_cost_nxt;
                    state_d    = S_DONE;
                end
            end
            default: begin
                // DONE: result strobe is on this cycle; nothing may return now
                if (i_cost_dval) err_d = 1'b1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            dmax_q     <= '0;
            ret_q      <= '0;
            ready_q    <= 1'b1;
            sim_dval_q <= 1'b0;
            sim_disp_q <= '0;
            dval_q     <= 1'b0;
            disp_q     <= '0;
            cost_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dmax_q     <= dmax_d;
            ret_q      <= ret_d;
            ready_q    <= ready_d;
            sim_dval_q <= sim_dval_d;
            sim_disp_q <= sim_disp_d;
            dval_q     <= dval_d;
            disp_q     <= disp_d;
            cost_q     <= cost_d;
            err_q      <= err_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_sim_dval = sim_dval_q;
    assign o_sim_disp = sim_disp_q;
    assign o_dval     = dval_q;
    assign o_disp     = disp_q;
    assign o_cost     = cost_q;
    assign o_err      = err_q;

endmodule
